vga_fb_scanout: RTL and testbench
=================================

Name: vga_fb_scanout

Overview:
Downstream consumer of the game FSM's pixel-write stream (mem_px_addr/mem_px_data/px_wr). It holds the 3-bit framebuffer and scans it out as 640x480@60 Hz VGA. Each framebuffer pixel is shown as a 4x4 block of screen pixels. It also emits a once-per-frame tick that the game logic uses for pacing.

Parameters:
AW, 15, framebuffer address width (depth 2^AW words)
DW, 3, pixel data width; bit2=R, bit1=G, bit0=B
FB_W, 160, visible framebuffer columns
FB_H, 120, visible framebuffer rows
FB_STRIDE, 176, framebuffer row stride in words (must match the writer's row pitch)
SCALE_LOG2, 2, log2 of the pixel replication factor (4x4)

Ports:
clk  in  1  25 MHz pixel clock; the only clock
rst  in  1  reset, asynchronous, active-low
px_wr  in  1  write strobe from the game FSM
mem_px_addr  in  AW  write address
mem_px_data  in  DW  write data
vga_hsync  out  1  horizontal sync, active-low
vga_vsync  out  1  vertical sync, active-low
vga_r  out  1  red
vga_g  out  1  green
vga_b  out  1  blue
frame_tick  out  1  one-cycle pulse at the start of vertical blanking

Behaviour:
- Reset (rst=0, asynchronous):
  - h_cnt=0, v_cnt=0; all pipeline valid/sync flags cleared.
  - vga_hsync=1, vga_vsync=1, vga_r/g/b=0, frame_tick=0.
  - Framebuffer contents are not cleared; the game FSM clears them.
  - Asserting reset mid-frame: outputs are idle immediately. After release, the first cycle is h=0,v=0.
- Horizontal timing: 800 clk per line.
  - visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
  - h_cnt wraps 799->0 and increments v_cnt.
- Vertical timing: 525 lines per frame.
  - visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
  - v_cnt wraps 524->0.
- Pipeline: latency 3 clk from counter value to pins.
  - S0: counters and raw sync/active decode.
  - S1: rd_addr = (v_cnt>>SCALE_LOG2)*FB_STRIDE + (h_cnt>>SCALE_LOG2), registered. Active also requires (h>>2)<FB_W and (v>>2)<FB_H.
  - S2: synchronous RAM read.
  - S3: output register.
  - hsync, vsync and active are delayed through matching stages, so sync-to-pixel alignment is exact.
- Pixel output: if active at S3, vga_r/g/b = rd_data[2]/[1]/[0]; otherwise all three are 0.
- Write port:
  - px_wr=1 writes mem_px_data to mem_px_addr at the clk edge.
  - No backpressure; every cycle's write is accepted.
  - Addresses >= 2^AW cannot occur because of the port width; no other address filtering.
- Read/write on the same address in the same cycle: the read returns old data (read-before-write). The new value is visible from the next frame's read.
- frame_tick: asserted for exactly one clk when the S0 counters reach h=0,v=480. It is not delayed by the pipeline.
- Widths:
  - h_cnt is 10 bits; v_cnt is 10 bits.
  - rd_addr arithmetic is done at AW+1 bits and truncated to AW. Maximum in-range address is 119*176+159=21103.

Decomposition:
- Shared package vga_pkg holds:
  - H_VIS/H_FP/H_SYNC/H_BP and V_* timing constants.
  - H_TOTAL=800, V_TOTAL=525.
  - Colour constants COLOR_BLACK=3'b000, COLOR_WHITE=3'b111.
- One sub-module, fb_dpram: simple dual-port RAM with write port (we/waddr/wdata) and a registered read port (raddr/rdata), read-before-write, inferable as block RAM.

Test Plan:
- Release reset, run 2 frames -> hsync period 800 clk with low width 96 starting at h=656. vsync period 420000 clk with low width 1600. frame_tick pulses every 420000 clk.
- Write 3'b111 at addr 0 and 3'b100 at addr 177, wait one frame -> screen pixels (0..3,0..3) are white. Pixels (4..7,4..7) are red only. Pixel (8,0) is black.
- Write 3'b010 at addr 159 (column 159, row 0) -> green appears at screen x=636..639. x=640 and beyond is 0 during blanking.
- Check pipeline alignment -> first visible pixel colour appears exactly 3 clk after h_cnt=0 on line 0, coincident with the delayed sync timing.
- Write addr 0 at the clk the scanout reads addr 0 -> old value is shown this frame and the new value next frame.
- Pull rst low at h=300,v=200 for 5 clk -> outputs go to hsync=vsync=1 and rgb=0 asynchronously. Counters restart at 0, and the next vsync low occurs 490 lines after release.

Source files
------------

// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and colour codes
// shared by the framebuffer scanout slice.
package vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = 800;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = 525;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port framebuffer RAM, read-before-write.
// Ports: clk; we/waddr/wdata write; raddr -> rdata (1 clk).
module fb_dpram #(
  parameter int AW = 15,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // NBA on both ports: a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (we)
      r_mem[waddr] <= wdata;
    rdata <= r_mem[raddr];
  end

endmodule

// File: rtl/vga_fb_scanout.sv
// 3-bit framebuffer scanned out as VGA with 4x4 replication.
// Ports: clk, rst (async low), px_wr/mem_px_addr/mem_px_data
// write port; vga_hsync/vsync/r/g/b pins; frame_tick pacing.
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int AW         = 15,
  parameter int DW         = 3,
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int FB_STRIDE  = 176,
  parameter int SCALE_LOG2 = 2,
  parameter int HV = vga_pkg::H_VIS,
  parameter int HF = vga_pkg::H_FP,
  parameter int HS = vga_pkg::H_SYNC,
  parameter int HB = vga_pkg::H_BP,
  parameter int VV = vga_pkg::V_VIS,
  parameter int VF = vga_pkg::V_FP,
  parameter int VS = vga_pkg::V_SYNC,
  parameter int VB = vga_pkg::V_BP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          px_wr,
  input  logic [AW-1:0] mem_px_addr,
  input  logic [DW-1:0] mem_px_data,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          vga_r,
  output logic          vga_g,
  output logic          vga_b,
  output logic          frame_tick
);

  localparam logic [9:0] L_H_LAST = 10'(HV + HF + HS + HB - 1);
  localparam logic [9:0] L_V_LAST = 10'(VV + VF + VS + VB - 1);
  localparam logic [9:0] L_HS_ON  = 10'(HV + HF);
  localparam logic [9:0] L_HS_OFF = 10'(HV + HF + HS);
  localparam logic [9:0] L_VS_ON  = 10'(VV + VF);
  localparam logic [9:0] L_VS_OFF = 10'(VV + VF + VS);
  localparam logic [9:0] L_HV     = 10'(HV);
  localparam logic [9:0] L_VV     = 10'(VV);
  localparam logic [9:0] L_FBW    = 10'(FB_W);
  localparam logic [9:0] L_FBH    = 10'(FB_H);
  localparam logic [AW:0] L_STRIDE = FB_STRIDE[AW:0];

  // S0: raster counters
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       w_h_last;
  logic       w_v_last;

  assign w_h_last = (r_h_cnt == L_H_LAST);
  assign w_v_last = (r_v_cnt == L_V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  assign frame_tick = (r_h_cnt == 10'd0) && (r_v_cnt == L_VV);

  // S0 decode
  logic w_hs0;
  logic w_vs0;
  logic w_act0;

  assign w_hs0 = !((r_h_cnt >= L_HS_ON) && (r_h_cnt < L_HS_OFF));
  assign w_vs0 = !((r_v_cnt >= L_VS_ON) && (r_v_cnt < L_VS_OFF));
  assign w_act0 = (r_h_cnt < L_HV) && (r_v_cnt < L_VV)
               && ((r_h_cnt >> SCALE_LOG2) < L_FBW)
               && ((r_v_cnt >> SCALE_LOG2) < L_FBH);

  // Address math one bit wider than AW, then truncated.
  logic [AW:0] w_row;
  logic [AW:0] w_col;
  logic [AW:0] w_sum;
  logic        w_unused;

  assign w_row    = {{(AW-9){1'b0}}, r_v_cnt >> SCALE_LOG2};
  assign w_col    = {{(AW-9){1'b0}}, r_h_cnt >> SCALE_LOG2};
  assign w_sum    = w_row * L_STRIDE + w_col;
  assign w_unused = w_sum[AW];

  // S1: read address and delayed decode
  logic [AW-1:0] r_rd_addr;
  logic          r_hs1;
  logic          r_vs1;
  logic          r_act1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr <= '0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_act1    <= 1'b0;
    end else begin
      r_rd_addr <= w_sum[AW-1:0];
      r_hs1     <= w_hs0;
      r_vs1     <= w_vs0;
      r_act1    <= w_act0;
    end
  end

  // S2: RAM read, flags follow
  logic [DW-1:0] w_rd_data;
  logic          r_hs2;
  logic          r_vs2;
  logic          r_act2;

  fb_dpram #(
    .AW (AW),
    .DW (DW)
  ) u_fb (
    .clk   (clk),
    .we    (px_wr),
    .waddr (mem_px_addr),
    .wdata (mem_px_data),
    .raddr (r_rd_addr),
    .rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
      r_act2 <= 1'b0;
    end else begin
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_act2 <= r_act1;
    end
  end

  // S3: pin registers; blanking forces black
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_r     <= COLOR_BLACK[2];
      vga_g     <= COLOR_BLACK[1];
      vga_b     <= COLOR_BLACK[0];
    end else begin
      vga_hsync <= r_hs2;
      vga_vsync <= r_vs2;
      vga_r     <= r_act2 ? w_rd_data[2] : COLOR_BLACK[2];
      vga_g     <= r_act2 ? w_rd_data[1] : COLOR_BLACK[1];
      vga_b     <= r_act2 ? w_rd_data[0] : COLOR_BLACK[0];
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Scoreboard bench for vga_fb_scanout (vertical timing
// shortened so several frames fit in a short run).
module tb_vga_fb_scanout;

  localparam int AW  = 15;
  localparam int HT  = 800;
  localparam int VV  = 8;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 2;
  localparam int FRM = HT * (VV + VF + VS + VB);

  localparam int K_RGB  = 0;
  localparam int K_HS   = 1;
  localparam int K_VS   = 2;
  localparam int K_TICK = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          px_wr = 1'b0;
  logic [AW-1:0] mem_px_addr = '0;
  logic [2:0]    mem_px_data = '0;
  logic          vga_hsync;
  logic          vga_vsync;
  logic          vga_r;
  logic          vga_g;
  logic          vga_b;
  logic          frame_tick;

  vga_fb_scanout #(
    .VV (VV),
    .VF (VF),
    .VS (VS),
    .VB (VB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .px_wr       (px_wr),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    int         kind;
    logic [2:0] v;
    string      nm;
  } sb_t;

  sb_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // cycles since reset release; counter value == cyc
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic int tpix(int f, int y, int x);
    return f * FRM + y * HT + x + 3;
  endfunction

  function automatic int ttick(int f);
    return f * FRM + VV * HT;
  endfunction

  task automatic expect_at(input int t, input int kind,
                           input logic [2:0] v, input string nm);
    sb_t e;
    int  i;
    e.t = t; e.kind = kind; e.v = v; e.nm = nm;
    i = q.size();
    while (i > 0 && q[i-1].t > t) i--;
    q.insert(i, e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // monitor: compare whatever is due at this cycle
  always @(negedge clk) begin : mon
    sb_t        e;
    logic [2:0] a;
    if (rst) begin
      while (q.size() > 0 && q[0].t <= cyc) begin
        e = q.pop_front();
        case (e.kind)
          K_RGB:   a = {vga_r, vga_g, vga_b};
          K_HS:    a = {2'b0, vga_hsync};
          K_VS:    a = {2'b0, vga_vsync};
          default: a = {2'b0, frame_tick};
        endcase
        checks++;
        if (e.t != cyc || a != e.v) begin
          errors++;
          $display("FAIL %s t=%0d cyc=%0d got=%0d exp=%0d",
                   e.nm, e.t, cyc, a, e.v);
        end
      end
    end
  end

  task automatic wr(input int a, input logic [2:0] d);
    @(negedge clk);
    px_wr = 1'b1;
    mem_px_addr = AW'(a);
    mem_px_data = d;
    @(negedge clk);
    px_wr = 1'b0;
  endtask

  task automatic drain(input string nm, input int lim);
    for (int i = 0; i < lim && q.size() > 0; i++)
      @(negedge clk);
    chk({nm, "_drain"}, q.size(), 0);
    q.delete();
  endtask

  task automatic wait_cyc(input int t);
    for (int i = 0; i < 4 * FRM && cyc < t; i++)
      @(negedge clk);
    chk("wait_cyc", cyc, t);
  endtask

  task automatic push_frame(input int f);
    int ys;
    ys = VV + VF;
    expect_at(tpix(f, 0, 655), K_HS, 3'd1, "hs_655");
    expect_at(tpix(f, 0, 656), K_HS, 3'd0, "hs_656");
    expect_at(tpix(f, 0, 751), K_HS, 3'd0, "hs_751");
    expect_at(tpix(f, 0, 752), K_HS, 3'd1, "hs_752");
    expect_at(tpix(f, 3, 656), K_HS, 3'd0, "hs_l3");
    expect_at(tpix(f, ys - 1, 799), K_VS, 3'd1, "vs_pre");
    expect_at(tpix(f, ys, 0), K_VS, 3'd0, "vs_on");
    expect_at(tpix(f, ys + VS - 1, 799), K_VS, 3'd0, "vs_end");
    expect_at(tpix(f, ys + VS, 0), K_VS, 3'd1, "vs_off");
    expect_at(ttick(f) - 1, K_TICK, 3'd0, "tick_pre");
    expect_at(ttick(f), K_TICK, 3'd1, "tick");
    expect_at(ttick(f) + 1, K_TICK, 3'd0, "tick_post");
    expect_at(tpix(f, 0, 0), K_RGB, 3'd7, "px_0_0");
  endtask

  initial begin : stim
    int trst;

    // load framebuffer under reset
    repeat (3) @(negedge clk);
    for (int a = 0; a < 352; a++) wr(a, 3'd0);
    wr(0, 3'b111);
    wr(177, 3'b100);
    wr(159, 3'b010);
    wr(250, 3'b110);

    chk("rst_hsync", vga_hsync, 1);
    chk("rst_vsync", vga_vsync, 1);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_tick", frame_tick, 0);

    expect_at(2, K_RGB, 3'd0, "pre_first_rgb");
    expect_at(2, K_HS, 3'd1, "pre_first_hs");
    expect_at(tpix(0, 0, 3), K_RGB, 3'd7, "px_3_0");
    expect_at(tpix(0, 3, 0), K_RGB, 3'd7, "px_0_3");
    expect_at(tpix(0, 3, 3), K_RGB, 3'd7, "px_3_3");
    expect_at(tpix(0, 0, 4), K_RGB, 3'd0, "px_4_0");
    expect_at(tpix(0, 0, 8), K_RGB, 3'd0, "px_8_0");
    expect_at(tpix(0, 4, 4), K_RGB, 3'd4, "px_4_4");
    expect_at(tpix(0, 7, 7), K_RGB, 3'd4, "px_7_7");
    expect_at(tpix(0, 4, 8), K_RGB, 3'd0, "px_8_4");
    expect_at(tpix(0, 4, 3), K_RGB, 3'd0, "px_3_4");
    expect_at(tpix(0, 0, 635), K_RGB, 3'd0, "px_635");
    expect_at(tpix(0, 0, 636), K_RGB, 3'd2, "px_636");
    expect_at(tpix(0, 3, 639), K_RGB, 3'd2, "px_639");
    expect_at(tpix(0, 0, 640), K_RGB, 3'd0, "px_640");
    expect_at(tpix(0, 0, 700), K_RGB, 3'd0, "px_700");
    expect_at(tpix(0, VV, 0), K_RGB, 3'd0, "px_vblank");
    push_frame(0);
    push_frame(1);

    @(negedge clk);
    #2 rst = 1'b1;
    drain("frames", 2 * FRM + 100);

    // collide write with the scanout read of addr 0
    expect_at(tpix(2, 0, 0), K_RGB, 3'd7, "rbw_old");
    expect_at(tpix(2, 0, 1), K_RGB, 3'd1, "rbw_next_px");
    expect_at(tpix(3, 0, 0), K_RGB, 3'd1, "rbw_new");
    wait_cyc(2 * FRM + 1);
    px_wr = 1'b1;
    mem_px_addr = '0;
    mem_px_data = 3'b001;
    @(negedge clk);
    px_wr = 1'b0;

    // async reset at counter (300,5)
    trst = 3 * FRM + 5 * HT + 300;
    expect_at(tpix(3, 5, 297), K_RGB, 3'd6, "pre_rst_px");
    wait_cyc(trst);
    #2 rst = 1'b0;
    #1;
    chk("arst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("arst_hsync", vga_hsync, 1);
    chk("arst_vsync", vga_vsync, 1);
    chk("arst_q_empty", q.size(), 0);
    repeat (5) @(negedge clk);
    chk("hold_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("hold_tick", frame_tick, 0);

    expect_at(2, K_RGB, 3'd0, "rel_pre_rgb");
    expect_at(tpix(0, 0, 0), K_RGB, 3'd1, "rel_px_0_0");
    expect_at(tpix(0, VV + VF - 1, 799), K_VS, 3'd1, "rel_vs_pre");
    expect_at(tpix(0, VV + VF, 0), K_VS, 3'd0, "rel_vs_on");
    expect_at(ttick(0) - 1, K_TICK, 3'd0, "rel_tick_pre");
    expect_at(ttick(0), K_TICK, 3'd1, "rel_tick");
    #2 rst = 1'b1;
    drain("post_rst", FRM + 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
